apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge.sv | 100 ++++++++++
 tb/tb_apb_master_bridge.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - command/response to APB master bridge with wait-state timeout
// One APB transfer per accepted command; the response is held until consumed.

module apb_master_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              pen,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    // The wait cycle that would bring the counter to TIMEOUT aborts; pready high wins.
    assign timed_out = !pready && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || timed_out) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cmd_ready is masked by prst so nothing is offered while reset is held.
    assign cmd_ready = (state == IDLE) && !prst;
    assign psel      = (state == SETUP) || (state == ACCESS);
    assign pen       = (state == ACCESS);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge pclk) begin
        if (prst) begin
            state     <= IDLE;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite <= cmd_write;
                        paddr  <= cmd_addr;
                        pwdata <= cmd_wdata;
                    end
                end
                SETUP: wait_cnt <= '0;
                ACCESS: begin
                    if (pready) begin
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (timed_out) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized self-checking bench for apb_master_bridge

module tb_apb_master_bridge;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic              pclk = 1'b0;
    logic              prst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              pen;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready = 1'b0;
    logic [DATA_W-1:0] prdata = '0;

    apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .pen(pen), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int last_setup = 0;
    int next_gap = 0;
    bit chained = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected behaviour: 'waits' low-pready ACCESS cycles then pready high.
    // TIMEOUT or more waits abort after exactly TIMEOUT ACCESS cycles.
    task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rd,
                           input int waits, input int bp, input bit hold);
        bit                err;
        int                n_acc;
        logic [DATA_W-1:0] exp_rd;
        err    = (waits >= TIMEOUT);
        n_acc  = err ? TIMEOUT : waits + 1;
        exp_rd = (err || wr) ? '0 : rd;

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        rsp_ready = 1'b0;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        @(negedge pclk);
        chk("setup_psel_pen", 32'({psel, pen}), 32'b10);
        chk("setup_paddr", 32'(paddr), 32'(addr));
        chk("setup_pwdata", 32'(pwdata), 32'(wdata));
        chk("setup_pwrite", 32'(pwrite), 32'(wr));
        chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        if (chained) chk("cmd_spacing", 32'(cyc - last_setup), 32'(next_gap));
        last_setup = cyc;
        if (!hold) cmd_valid = 1'b0;
        pready = 1'($urandom);
        prdata = DATA_W'($urandom);

        for (int i = 0; i < n_acc; i++) begin
            @(negedge pclk);
            chk("access_psel_pen", 32'({psel, pen}), 32'b11);
            chk("access_paddr", 32'(paddr), 32'(addr));
            chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
            pready = (i == waits);
            prdata = (i == waits) ? rd : DATA_W'($urandom);
        end

        @(negedge pclk);
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_psel_pen", 32'({psel, pen}), 32'b00);
        chk("resp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("resp_err", 32'(rsp_err), 32'(err));
        chk("resp_paddr_kept", 32'(paddr), 32'(addr));
        pready = 1'($urandom);
        prdata = DATA_W'($urandom);

        for (int k = 0; k < bp; k++) begin
            @(negedge pclk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", 32'(rsp_rdata), 32'(exp_rd));
            chk("bp_err", 32'(rsp_err), 32'(err));
            chk("bp_psel", 32'(psel), 32'd0);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end

        rsp_ready = 1'b1;
        @(negedge pclk);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_psel", 32'(psel), 32'd0);
        chk("idle_ready_again", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b0;
        chained   = hold;
        next_gap  = n_acc + 3 + bp;
    endtask

    initial begin
        int r;
        int w;

        repeat (2) @(negedge pclk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_outputs", 32'({psel, pen, pwrite, rsp_valid, rsp_err}), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", 32'(pwdata), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        prst = 1'b0;
        #1;
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        run_txn(1'b1, 8'h10, 8'hA5, 8'h77, 0, 0, 1'b1);
        run_txn(1'b0, 8'h22, 8'h00, 8'h5C, 3, 0, 1'b1);
        run_txn(1'b0, 8'h33, 8'h00, 8'h99, TIMEOUT, 5, 1'b1);
        run_txn(1'b0, 8'h44, 8'h00, 8'hC3, TIMEOUT - 1, 0, 1'b1);
        run_txn(1'b1, 8'h55, 8'h3C, 8'hFF, TIMEOUT + 2, 2, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      w = $urandom_range(0, 3);
            else if (r < 8) w = $urandom_range(4, TIMEOUT - 2);
            else            w = $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
            run_txn(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                    w, $urandom_range(0, 3), 1'($urandom));
        end
        cmd_valid = 1'b0;
        chained   = 1'b0;

        // Reset while in ACCESS: transfer dropped, no response afterwards.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'hE7;
        cmd_wdata = 8'h81;
        @(negedge pclk);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        @(negedge pclk);
        chk("mid_access_pen", 32'({psel, pen}), 32'b11);
        prst = 1'b1;
        @(negedge pclk);
        chk("mid_rst_outputs", 32'({psel, pen, pwrite, rsp_valid, rsp_err}), 32'd0);
        chk("mid_rst_paddr", 32'(paddr), 32'd0);
        chk("mid_rst_pwdata", 32'(pwdata), 32'd0);
        chk("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        prst = 1'b0;
        #1;
        chk("mid_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge pclk);
        chk("mid_rel_no_rsp", 32'(rsp_valid), 32'd0);
        chk("mid_rel_no_psel", 32'(psel), 32'd0);

        run_txn(1'b0, 8'h01, 8'h00, 8'h6E, 1, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
